// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a CPU and a DMA requester.
// Each granted access runs a fixed IDLE -> ISSUE -> WAIT -> DONE sequence.
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          pick_dma;

    // On a tie the requester that did not own the last grant wins.
    assign pick_dma = dma_req && (!cpu_req || !owner_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    state_d = ISSUE;
                    owner_d = pick_dma;
                    we_d    = pick_dma ? dma_we : cpu_we;
                    addr_d  = pick_dma ? dma_addr : cpu_addr;
                    wdata_d = pick_dma ? dma_wdata : cpu_wdata;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data arrives during WAIT; only the owner's register captures it.
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        if (state_q == WAIT && !we_q) begin
            if (owner_q) begin
                dma_rdata_d = mem_rdata;
            end else begin
                cpu_rdata_d = mem_rdata;
            end
        end
    end

    always_comb begin
        mem_en  = (state_q == ISSUE);
        mem_we  = (state_q == ISSUE) && we_q;
        cpu_ack = (state_q == DONE) && !owner_q;
        dma_ack = (state_q == DONE) && owner_q;
        busy    = (state_q != IDLE);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule
